// File: rtl/hsem_pkg.sv
// Shared constants for the HSEM interrupt/error controller: register map,
// EINFO field layout and the parameter limits.
package hsem_pkg;

  localparam int MAX_SEM  = 32;
  localparam int MAX_CORE = 8;

  typedef enum logic [2:0] {
    REG_IER       = 3'd0,
    REG_ICR       = 3'd1,
    REG_ISR       = 3'd2,
    REG_MISR      = 3'd3,
    REG_ESR       = 3'd4,
    REG_ECR       = 3'd5,
    REG_EINFO     = 3'd6,
    REG_EINFO_CLR = 3'd7
  } reg_idx_e;

  localparam int EINFO_VALID    = 31;
  localparam int EINFO_OVF      = 30;
  localparam int EINFO_CODE_LSB = 16;
  localparam int EINFO_CORE_LSB = 8;
  localparam int EINFO_SEM_LSB  = 0;

  // Code width is a parameter of the controller, so it lives outside this struct.
  typedef struct packed {
    logic       vld;
    logic       ovf;
    logic [2:0] core;
    logic [4:0] sem;
  } einfo_hdr_t;

endpackage

// File: rtl/hsem_int_bank.sv
// One core's interrupt bank: IER/ISR/ESR/ECR, the interrupt level and the
// level-or-pulse output stage.
module hsem_int_bank
  import hsem_pkg::*;
#(
  parameter int NUM_SEM    = 32,
  parameter int ERR_W      = 4,
  parameter bit INTR_PULSE = 1'b0
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NUM_SEM-1:0] sem_free,
  input  logic               err_set,
  input  logic [ERR_W-1:0]   err_code,
  input  logic               ier_we,
  input  logic               icr_we,
  input  logic               esr_we,
  input  logic               ecr_we,
  input  logic [NUM_SEM-1:0] wdata_sem,
  input  logic [ERR_W-1:0]   wdata_err,
  input  logic               wdata_ie,
  output logic [NUM_SEM-1:0] ier,
  output logic [NUM_SEM-1:0] isr,
  output logic [ERR_W-1:0]   esr,
  output logic               errie,
  output logic               intr
);

  logic lvl;

  assign lvl = (|(isr & ier)) | (errie & (|esr));

  // Sets are ORed in after the W1C mask so a same-edge set survives the clear;
  // ISR qualifies against the pre-write IER, so enabling never back-fills.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ier   <= '0;
      isr   <= '0;
      esr   <= '0;
      errie <= 1'b0;
    end else begin
      if (ier_we) ier <= wdata_sem;
      isr <= (isr & ~(icr_we ? wdata_sem : '0)) | (sem_free & ier);
      esr <= (esr & ~(esr_we ? wdata_err : '0)) | (err_set ? err_code : '0);
      if (ecr_we) errie <= wdata_ie;
    end
  end

  generate
    if (INTR_PULSE) begin : g_pulse
      logic lvl_q;
      always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
          lvl_q <= 1'b0;
          intr  <= 1'b0;
        end else begin
          lvl_q <= lvl;
          intr  <= lvl & ~lvl_q;
        end
      end
    end else begin : g_level
      always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) intr <= 1'b0;
        else          intr <= lvl;
      end
    end
  endgenerate

endmodule

// File: rtl/hsem_int_ctrl.sv
// HSEM interrupt/error controller top: per-core banks, first-error capture
// (EINFO), register write decode and registered read mux.
module hsem_int_ctrl
  import hsem_pkg::*;
#(
  parameter int NUM_SEM    = 32,
  parameter int NUM_CORE   = 4,
  parameter int ERR_W      = 4,
  parameter bit INTR_PULSE = 1'b0
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic [NUM_SEM-1:0]  sem_free,
  input  logic                err_vld,
  input  logic [ERR_W-1:0]    err_code,
  input  logic [2:0]          err_core,
  input  logic [4:0]          err_sem,
  input  logic                reg_wr,
  input  logic                reg_rd,
  input  logic [2:0]          reg_addr,
  input  logic [2:0]          reg_core,
  input  logic [31:0]         reg_wdata,
  output logic [31:0]         reg_rdata,
  output logic [NUM_CORE-1:0] intr
);

  logic [NUM_CORE-1:0][NUM_SEM-1:0] ier, isr;
  logic [NUM_CORE-1:0][ERR_W-1:0]   esr;
  logic [NUM_CORE-1:0]              errie;
  logic [NUM_CORE-1:0]              bank_wr;
  reg_idx_e                         addr;
  einfo_hdr_t                       einfo;
  logic [ERR_W-1:0]                 einfo_code;
  logic                             einfo_clr;
  logic [31:0]                      rd_next;
  logic                             unused_wdata;

  assign addr         = reg_idx_e'(reg_addr);
  assign einfo_clr    = reg_wr && (addr == REG_EINFO_CLR);
  assign unused_wdata = ^reg_wdata;

  // Out-of-range reg_core / err_core simply match no bank.
  generate
    for (genvar c = 0; c < NUM_CORE; c++) begin : g_bank
      assign bank_wr[c] = reg_wr && (reg_core == 3'(c));
      hsem_int_bank #(
        .NUM_SEM   (NUM_SEM),
        .ERR_W     (ERR_W),
        .INTR_PULSE(INTR_PULSE)
      ) u_bank (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .sem_free (sem_free),
        .err_set  (err_vld && (err_core == 3'(c))),
        .err_code (err_code),
        .ier_we   (bank_wr[c] && (addr == REG_IER)),
        .icr_we   (bank_wr[c] && (addr == REG_ICR)),
        .esr_we   (bank_wr[c] && (addr == REG_ESR)),
        .ecr_we   (bank_wr[c] && (addr == REG_ECR)),
        .wdata_sem(reg_wdata[NUM_SEM-1:0]),
        .wdata_err(reg_wdata[ERR_W-1:0]),
        .wdata_ie (reg_wdata[0]),
        .ier      (ier[c]),
        .isr      (isr[c]),
        .esr      (esr[c]),
        .errie    (errie[c]),
        .intr     (intr[c])
      );
    end
  endgenerate

  // A clear arriving with a new error re-arms capture in the same edge.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      einfo      <= '0;
      einfo_code <= '0;
    end else if (err_vld) begin
      if (!einfo.vld || einfo_clr) begin
        einfo      <= '{vld: 1'b1, ovf: 1'b0, core: err_core, sem: err_sem};
        einfo_code <= err_code;
      end else begin
        einfo.ovf  <= 1'b1;
      end
    end else if (einfo_clr) begin
      einfo.vld <= 1'b0;
      einfo.ovf <= 1'b0;
    end
  end

  always_comb begin
    rd_next = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      if (reg_core == 3'(c)) begin
        case (addr)
          REG_IER:  rd_next[NUM_SEM-1:0] = ier[c];
          REG_ISR:  rd_next[NUM_SEM-1:0] = isr[c];
          REG_MISR: rd_next[NUM_SEM-1:0] = isr[c] & ier[c];
          REG_ESR:  rd_next[ERR_W-1:0]   = esr[c];
          REG_ECR:  rd_next[0]           = errie[c];
          default:  ;
        endcase
      end
    end
    if (addr == REG_EINFO) begin
      rd_next[EINFO_VALID]              = einfo.vld;
      rd_next[EINFO_OVF]                = einfo.ovf;
      rd_next[EINFO_CODE_LSB +: ERR_W]  = einfo_code;
      rd_next[EINFO_CORE_LSB +: 3]      = einfo.core;
      rd_next[EINFO_SEM_LSB +: 5]       = einfo.sem;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)    reg_rdata <= '0;
    else if (reg_rd) reg_rdata <= rd_next;
  end

endmodule

// File: tb/tb_hsem_int_ctrl.sv
// Bench for hsem_int_ctrl: a level-mode and a pulse-mode instance share stimulus
// and are compared every cycle against a register-level model, plus pinned literals.
module tb_hsem_int_ctrl;

  localparam int NC = 4;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b1;
  logic [31:0] sem_free = '0;
  logic        err_vld = 1'b0;
  logic [3:0]  err_code = '0;
  logic [2:0]  err_core = '0;
  logic [4:0]  err_sem = '0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [2:0]  reg_addr = '0;
  logic [2:0]  reg_core = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] rdata_l, rdata_p;
  logic [NC-1:0] intr_l, intr_p;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  hsem_int_ctrl #(.NUM_SEM(32), .NUM_CORE(NC), .ERR_W(4), .INTR_PULSE(1'b0)) u_lvl (
    .hclk(hclk), .hresetn(hresetn), .sem_free(sem_free), .err_vld(err_vld),
    .err_code(err_code), .err_core(err_core), .err_sem(err_sem), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_core(reg_core), .reg_wdata(reg_wdata),
    .reg_rdata(rdata_l), .intr(intr_l));

  hsem_int_ctrl #(.NUM_SEM(32), .NUM_CORE(NC), .ERR_W(4), .INTR_PULSE(1'b1)) u_pul (
    .hclk(hclk), .hresetn(hresetn), .sem_free(sem_free), .err_vld(err_vld),
    .err_code(err_code), .err_core(err_core), .err_sem(err_sem), .reg_wr(reg_wr),
    .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_core(reg_core), .reg_wdata(reg_wdata),
    .reg_rdata(rdata_p), .intr(intr_p));

  initial forever #5 hclk = ~hclk;

  // ---------------- reference model ----------------
  logic [31:0]   m_ier [NC];
  logic [31:0]   m_isr [NC];
  logic [31:0]   m_esr [NC];
  bit            m_errie [NC];
  bit            m_v, m_o;
  logic [31:0]   m_code, m_core, m_sem, m_rdata;
  logic [NC-1:0] m_il, m_ip, m_prev;

  function automatic logic [31:0] mread(input int a, input int c);
    if (a == 6) return {m_v, m_o, 14'b0} << 16 | (m_code << 16) | (m_core << 8) | m_sem;
    if (a == 7 || c >= NC) return 32'h0;
    case (a)
      0: return m_ier[c];
      2: return m_isr[c];
      3: return m_isr[c] & m_ier[c];
      4: return m_esr[c];
      5: return {31'b0, m_errie[c]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      m_ier[c] = 0; m_isr[c] = 0; m_esr[c] = 0; m_errie[c] = 0;
    end
    m_v = 0; m_o = 0; m_code = 0; m_core = 0; m_sem = 0; m_rdata = 0;
    m_il = 0; m_ip = 0; m_prev = 0;
  endtask

  task automatic model_step();
    logic [NC-1:0] lvl;
    logic [31:0]   clr, w1c;
    bit            wc, eclr;
    for (int c = 0; c < NC; c++)
      lvl[c] = ((m_isr[c] & m_ier[c]) != 0) || (m_errie[c] && m_esr[c] != 0);
    if (reg_rd) m_rdata = mread(int'(reg_addr), int'(reg_core));
    m_il   = lvl;
    m_ip   = lvl & ~m_prev;
    m_prev = lvl;
    for (int c = 0; c < NC; c++) begin
      wc  = reg_wr && (int'(reg_core) == c);
      clr = (wc && reg_addr == 1) ? reg_wdata : 32'h0;
      w1c = (wc && reg_addr == 4) ? (reg_wdata & 32'hF) : 32'h0;
      m_isr[c] = (m_isr[c] & ~clr) | (sem_free & m_ier[c]);
      if (wc && reg_addr == 0) m_ier[c] = reg_wdata;
      m_esr[c] = (m_esr[c] & ~w1c) | ((err_vld && int'(err_core) == c) ? {28'b0, err_code} : 32'h0);
      if (wc && reg_addr == 5) m_errie[c] = reg_wdata[0];
    end
    eclr = reg_wr && reg_addr == 7;
    if (err_vld) begin
      if (!m_v || eclr) begin
        m_v = 1; m_o = 0;
        m_code = {28'b0, err_code}; m_core = {29'b0, err_core}; m_sem = {27'b0, err_sem};
      end else m_o = 1;
    end else if (eclr) begin
      m_v = 0; m_o = 0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge hclk or negedge hresetn);
      if (!hresetn) model_clear();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge hclk);
    if (cmp_en) begin
      chk("intr_level", 32'(intr_l), 32'(m_il));
      chk("intr_pulse", 32'(intr_p), 32'(m_ip));
      chk("rdata_level", rdata_l, m_rdata);
      chk("rdata_pulse", rdata_p, m_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    sem_free = 0; err_vld = 0; reg_wr = 0; reg_rd = 0;
  endtask

  task automatic wr(input int a, input int c, input logic [31:0] d);
    reg_wr = 1; reg_addr = 3'(a); reg_core = 3'(c); reg_wdata = d;
    @(negedge hclk);
    reg_wr = 0;
  endtask

  task automatic rd(input int a, input int c, output logic [31:0] v);
    reg_rd = 1; reg_addr = 3'(a); reg_core = 3'(c);
    @(negedge hclk);
    reg_rd = 0;
    v = rdata_l;
  endtask

  task automatic free(input logic [31:0] v);
    sem_free = v;
    @(negedge hclk);
    sem_free = 0;
  endtask

  task automatic err(input int code, input int core, input int sem);
    err_vld = 1; err_code = 4'(code); err_core = 3'(core); err_sem = 5'(sem);
    @(negedge hclk);
    err_vld = 0;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sem_free  = $urandom & $urandom;
      err_vld   = ($urandom_range(0, 4) == 0);
      err_code  = 4'($urandom_range(0, 15));
      err_core  = 3'($urandom_range(0, 5));
      err_sem   = 5'($urandom_range(0, 31));
      reg_wr    = ($urandom_range(0, 2) == 0);
      reg_rd    = ($urandom_range(0, 1) == 0);
      reg_addr  = 3'($urandom_range(0, 7));
      reg_core  = 3'($urandom_range(0, 5));
      reg_wdata = $urandom;
      @(negedge hclk);
    end
    idle();
  endtask

  initial begin
    logic [31:0] v;
    int cnt;
    #3 hresetn = 0;
    repeat (2) @(negedge hclk);
    chk("reset_intr", 32'(intr_l), 32'h0);
    chk("reset_rdata", rdata_l, 32'h0);
    hresetn = 1;
    cmp_en  = 1;
    @(negedge hclk);

    // enabled release raises ISR/MISR and intr; ICR clears it
    wr(0, 1, 32'h5);
    free(32'h7);
    rd(2, 1, v);
    chk("isr1", v, 32'h5);
    chk("intr_core1", 32'(intr_l), 32'h2);
    chk("pulse_core1", 32'(intr_p), 32'h2);
    rd(3, 1, v);
    chk("misr1", v, 32'h5);
    chk("pulse_core1_gone", 32'(intr_p), 32'h0);
    wr(1, 1, 32'h5);
    chk("intr_after_icr_edge", 32'(intr_l), 32'h2);
    @(negedge hclk);
    chk("intr_cleared", 32'(intr_l), 32'h0);
    wr(0, 1, 32'h0);

    // no retroactive set from a release seen while disabled
    free(32'h8);
    wr(0, 0, 32'h8);
    rd(2, 0, v);
    chk("isr0_no_retro", v, 32'h0);
    chk("intr0_low", 32'(intr_l[0]), 32'h0);
    wr(0, 0, 32'h0);

    // error capture, overflow, clear
    wr(5, 2, 32'h1);
    err(2, 2, 9);
    rd(4, 2, v);
    chk("esr2", v, 32'h2);
    rd(6, 0, v);
    chk("einfo_first", v, 32'h8002_0209);
    chk("intr_err2", 32'(intr_l[2]), 32'h1);
    err(1, 0, 3);
    rd(6, 0, v);
    chk("einfo_ovf", v, 32'hC002_0209);
    wr(7, 0, 32'h1);
    rd(6, 0, v);
    chk("einfo_clr_flags", {30'b0, v[31:30]}, 32'h0);
    err(5, 6, 4);
    rd(4, 0, v);
    chk("esr0_unchanged_by_oor", v, 32'h1);
    wr(4, 2, 32'hF); wr(4, 0, 32'hF); wr(5, 2, 32'h0); wr(7, 0, 32'h0);

    // same-edge set vs W1C, and same-edge clear vs new error
    wr(0, 0, 32'h1);
    reg_wr = 1; reg_addr = 3'd1; reg_core = 3'd0; reg_wdata = 32'h1; sem_free = 32'h1;
    @(negedge hclk);
    idle();
    rd(2, 0, v);
    chk("set_beats_w1c", v, 32'h1);
    wr(1, 0, 32'h1); wr(0, 0, 32'h0);
    err(8, 3, 1);
    err(1, 0, 2);
    reg_wr = 1; reg_addr = 3'd7; reg_wdata = 32'h0;
    err_vld = 1; err_code = 4'h4; err_core = 3'd1; err_sem = 5'd17;
    @(negedge hclk);
    idle();
    rd(6, 0, v);
    chk("einfo_clr_with_err", v, 32'h8004_0111);
    wr(4, 1, 32'hF); wr(4, 3, 32'hF); wr(4, 0, 32'hF); wr(7, 0, 32'h0);

    // pulse mode: one pulse per level rise
    wr(0, 3, 32'h10);
    free(32'h10);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin @(negedge hclk); cnt += int'(intr_p[3]); end
    chk("pulse_count_first", 32'(cnt), 32'h1);
    wr(1, 3, 32'h10);
    repeat (2) @(negedge hclk);
    free(32'h10);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin @(negedge hclk); cnt += int'(intr_p[3]); end
    chk("pulse_count_second", 32'(cnt), 32'h1);
    wr(1, 3, 32'h10); wr(0, 3, 32'h0);

    // random burst, reset in the middle of it, then more random traffic
    rand_cycles(1500);
    wr(0, 0, 32'hFFFF_FFFF); wr(0, 1, 32'hFFFF_FFFF); wr(0, 2, 32'hFFFF_FFFF); wr(0, 3, 32'hFFFF_FFFF);
    free(32'hFFFF_FFFF);
    rd(2, 0, v);
    @(posedge hclk);
    #2 hresetn = 0;
    #1;
    chk("async_rst_intr_l", 32'(intr_l), 32'h0);
    chk("async_rst_intr_p", 32'(intr_p), 32'h0);
    chk("async_rst_rdata", rdata_l, 32'h0);
    @(negedge hclk);
    idle();
    @(negedge hclk);
    hresetn = 1;
    @(negedge hclk);
    for (int c = 0; c < NC; c++) begin
      for (int a = 0; a < 6; a++) begin
        rd(a, c, v);
        chk("post_reset_reg", v, 32'h0);
      end
    end
    rd(6, 0, v);
    chk("post_reset_einfo", v, 32'h0);
    rand_cycles(1500);

    repeat (3) @(negedge hclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsem_int_ctrl.md
# hsem_int_ctrl

Parametrised interrupt and error controller for the hardware semaphore (HSEM) block. It gathers semaphore-release events and semaphore access errors, keeps per-core enable/status/error registers, captures the first error's details, and drives one interrupt line per core. It sits between the HSEM lock engine and the AHB register decoder; its interrupt outputs go straight to the cores.

## Interface
- NUM_SEM, 32: number of semaphores, 1..32; one status bit each.
- NUM_CORE, 4: number of cores/interrupt lines, 1..8.
- ERR_W, 4: width of the error-code vector from the lock engine.
- INTR_PULSE, 0: 0 = level interrupts; 1 = one-cycle pulse per rising edge of the level.
- hclk  in  1  clock.
- hresetn  in  1  reset, asynchronous, active-low.
- sem_free  in  NUM_SEM  one-cycle pulse per semaphore released.
- err_vld  in  1  one-cycle error event strobe.
- err_code  in  ERR_W  error cause bits, valid with err_vld.
- err_core  in  3  core ID that caused the error.
- err_sem  in  5  semaphore index involved.
- reg_wr  in  1  register write strobe.
- reg_rd  in  1  register read strobe.
- reg_addr  in  3  register word index.
- reg_core  in  3  core bank selected for per-core registers.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, registered.
- intr  out  NUM_CORE  interrupt per core.

## Operation
- Per-core registers (bank = reg_core): 0 IER RW, NUM_SEM bits; 1 ICR W1C on ISR, reads 0; 2 ISR RO; 3 MISR RO = ISR & IER; 4 ESR, ERR_W bits, W1C on write; 5 ECR RW, bit0 ERRIE.
- Global registers: 6 EINFO RO = {valid[31], ovf[30], code[ERR_W+15:16], core[10:8], sem[4:0]}; 7 EINFO_CLR, any write clears valid and ovf.
- sem_free[i] sets ISR[c][i] only in cores whose IER[c][i] = 1 in the same cycle.
- err_vld ORs err_code into ESR[err_core]. If err_core >= NUM_CORE, the ESR update is dropped; EINFO still captures.
- EINFO: the first err_vld while valid = 0 loads code/core/sem and sets valid. A later err_vld while valid = 1 sets ovf and leaves the fields unchanged.
- Level: lvl[c] = |MISR[c] | (ERRIE[c] & |ESR[c]).
- INTR_PULSE=0: intr = lvl, registered. INTR_PULSE=1: intr[c] pulses for one cycle when lvl[c] rises.
- Out-of-range reg_core (>= NUM_CORE) or unused bits: writes ignored, reads 0.
- Simultaneous events:
  - Set and W1C on the same bit: set wins, bit stays 1.
  - EINFO_CLR with err_vld: the new error is captured, valid = 1, ovf = 0.
  - Clearing an IER bit does not clear ISR; MISR drops immediately.
- Reset: every register, reg_rdata and intr go to 0. Reset mid-operation discards pending status and any pulse.

## Timing
- Status registers update on the hclk edge that samples the event or write.
- intr follows one cycle after the status change: event at edge N, ISR set at N, intr high after N+1.
- A W1C at edge N deasserts level intr after N+1.
- Read: reg_rd with reg_addr at edge N gives reg_rdata valid after N until the next read. The read shows state before any same-edge write.
- Back-to-back events every cycle are accepted; there is no backpressure.

## Structure
- Package hsem_pkg holds the register index constants (IER..EINFO_CLR), EINFO bit positions, and the max NUM_SEM/NUM_CORE limits.
- Sub-module hsem_int_bank is instantiated once per core via generate. It holds IER, ISR, ESR, ECR and the level/pulse logic.
- The top holds EINFO, the write-enable decode and the read mux.

## Test plan
- Enable IER[1] = 0x5, pulse sem_free = 0x7: ISR[1] = 0x5, MISR[1] = 0x5, intr = 0b0010 one cycle later. ICR[1] = 0x5 clears intr the cycle after.
- IER[0] = 0: pulse sem_free[3], then IER[0] = 0x8. ISR stays 0 and intr[0] stays low (no retroactive set).
- Error sequence: ERRIE[2] = 1; err_vld with code 0x2, core 2, sem 9 gives ESR[2] = 0x2, EINFO = 0x8002_0209, intr[2] = 1. A second error sets ovf (EINFO bit30); EINFO_CLR then zeroes it.
- Same-cycle ICR[0] = 0x1 with sem_free[0]: ISR[0] bit0 remains 1. Same-cycle EINFO_CLR with err_vld: new fields captured, ovf = 0.
- INTR_PULSE = 1: hold ISR set for 5 cycles, giving exactly one 1-cycle intr pulse. Clear, then a new event gives a second pulse.
- Assert hresetn low mid-burst: all outputs 0 asynchronously, and registers read 0 after release.
